mem_port_arbiter: RTL and testbench

Arbitrates the single unified memory port between the instruction-fetch requester and the MEM-stage load/store requester of the pipeline. Grants one requester at a time with round-robin tie-breaking, drives the memory handshake, returns read data with a one-cycle done pulse, and produces the pipeline stall signals for each requester. A hung memory is detected by a timeout that aborts the transfer and sets a sticky error flag.

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and stall signals of the unified memory port.
// master = arbiter side, slave = pipeline/memory side.
interface mem_port_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_done;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_done;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        stall_if;
   logic        stall_mem;
   logic        bus_err;

   modport master (
      input  if_req, if_addr, dm_req, dm_we,
      input  dm_addr, dm_wdata, mem_rdata, mem_ack,
      output if_rdata, if_done, dm_rdata, dm_done,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output stall_if, stall_mem, bus_err
   );

   modport slave (
      output if_req, if_addr, dm_req, dm_we,
      output dm_addr, dm_wdata, mem_rdata, mem_ack,
      input  if_rdata, if_done, dm_rdata, dm_done,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  stall_if, stall_mem, bus_err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter between fetch and load/store on one memory port,
// with ack timeout abort and sticky bus error.
module mem_port_arbiter #(
   parameter logic [7:0]  TIMEOUT  = 8'd255,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input logic              clk,
   input logic              rst,
   mem_port_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY_IF,
      BUSY_DM
   } state_t;

   state_t      state_q, state_d;
   logic        mem_en_q, mem_en_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        if_done_q, if_done_d;
   logic        dm_done_q, dm_done_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic [31:0] dm_rdata_q, dm_rdata_d;
   logic        bus_err_q, bus_err_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        lg_dm_q, lg_dm_d;

   logic if_elig, dm_elig, pick_dm, pick_if;
   logic expired;

   // A request completing this cycle is not eligible again yet.
   assign if_elig = bus.if_req & ~if_done_q;
   assign dm_elig = bus.dm_req & ~dm_done_q;
   assign pick_dm = dm_elig & (~if_elig | ~lg_dm_q);
   assign pick_if = if_elig & ~pick_dm;
   assign expired = (cnt_q == TIMEOUT - 8'd1);

   always_comb begin
      state_d     = state_q;
      mem_en_d    = mem_en_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_done_d   = 1'b0;
      dm_done_d   = 1'b0;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      bus_err_d   = bus_err_q;
      cnt_d       = cnt_q;
      lg_dm_d     = lg_dm_q;
      unique case (state_q)
         IDLE: begin
            if (pick_dm) begin
               state_d     = BUSY_DM;
               mem_en_d    = 1'b1;
               mem_we_d    = bus.dm_we;
               mem_addr_d  = bus.dm_addr;
               mem_wdata_d = bus.dm_wdata;
               lg_dm_d     = 1'b1;
               cnt_d       = 8'd0;
            end else if (pick_if) begin
               state_d     = BUSY_IF;
               mem_en_d    = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = bus.if_addr;
               mem_wdata_d = 32'd0;
               lg_dm_d     = 1'b0;
               cnt_d       = 8'd0;
            end
         end
         BUSY_IF: begin
            if (bus.mem_ack) begin
               if_rdata_d = bus.mem_rdata;
               if_done_d  = 1'b1;
               mem_en_d   = 1'b0;
               state_d    = IDLE;
            end else if (expired) begin
               if_rdata_d = ERR_DATA;
               if_done_d  = 1'b1;
               bus_err_d  = 1'b1;
               mem_en_d   = 1'b0;
               state_d    = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         BUSY_DM: begin
            if (bus.mem_ack) begin
               if (!mem_we_q) dm_rdata_d = bus.mem_rdata;
               dm_done_d = 1'b1;
               mem_en_d  = 1'b0;
               state_d   = IDLE;
            end else if (expired) begin
               dm_rdata_d = ERR_DATA;
               dm_done_d  = 1'b1;
               bus_err_d  = 1'b1;
               mem_en_d   = 1'b0;
               state_d    = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         if_done_q   <= 1'b0;
         dm_done_q   <= 1'b0;
         if_rdata_q  <= 32'd0;
         dm_rdata_q  <= 32'd0;
         bus_err_q   <= 1'b0;
         cnt_q       <= 8'd0;
         lg_dm_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_done_q   <= if_done_d;
         dm_done_q   <= dm_done_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         bus_err_q   <= bus_err_d;
         cnt_q       <= cnt_d;
         lg_dm_q     <= lg_dm_d;
      end
   end

   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_done   = if_done_q;
   assign bus.dm_done   = dm_done_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.bus_err   = bus_err_q;
   assign bus.stall_if  = bus.if_req & ~if_done_q;
   assign bus.stall_mem = bus.dm_req & ~dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with hand-computed expectations.
// TIMEOUT is set to 4 so the abort path is reachable quickly.
module tb_mem_port_arbiter;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   mem_port_arbiter_if bus();

   mem_port_arbiter #(
      .TIMEOUT  (8'd4),
      .ERR_DATA (32'hDEAD_BEEF)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      bus.if_req = 1'b0;
      bus.if_addr = 32'd0;
      bus.dm_req = 1'b0;
      bus.dm_we = 1'b0;
      bus.dm_addr = 32'd0;
      bus.dm_wdata = 32'd0;
      bus.mem_rdata = 32'd0;
      bus.mem_ack = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // reset state
      chk("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
      chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
      chk("rst_if_done", {31'd0, bus.if_done}, 32'd0);
      chk("rst_dm_done", {31'd0, bus.dm_done}, 32'd0);
      chk("rst_if_rdata", bus.if_rdata, 32'd0);
      chk("rst_dm_rdata", bus.dm_rdata, 32'd0);
      chk("rst_bus_err", {31'd0, bus.bus_err}, 32'd0);

      // single fetch
      bus.if_req = 1'b1;
      bus.if_addr = 32'h100;
      #1;
      chk("f_stall_t", {31'd0, bus.stall_if}, 32'd1);
      tick();
      chk("f_mem_en", {31'd0, bus.mem_en}, 32'd1);
      chk("f_mem_addr", bus.mem_addr, 32'h100);
      chk("f_mem_we", {31'd0, bus.mem_we}, 32'd0);
      chk("f_stall_t1", {31'd0, bus.stall_if}, 32'd1);
      chk("f_done_t1", {31'd0, bus.if_done}, 32'd0);
      bus.mem_ack = 1'b1;
      bus.mem_rdata = 32'h1234_5678;
      tick();
      chk("f_done", {31'd0, bus.if_done}, 32'd1);
      chk("f_rdata", bus.if_rdata, 32'h1234_5678);
      chk("f_en_off", {31'd0, bus.mem_en}, 32'd0);
      chk("f_stall_off", {31'd0, bus.stall_if}, 32'd0);
      bus.if_req = 1'b0;
      bus.mem_ack = 1'b0;
      tick();
      chk("f_done_pulse", {31'd0, bus.if_done}, 32'd0);
      chk("f_no_regrant", {31'd0, bus.mem_en}, 32'd0);

      // simultaneous requests after reset: DM first
      do_reset();
      bus.if_req = 1'b1;
      bus.if_addr = 32'h100;
      bus.dm_req = 1'b1;
      bus.dm_we = 1'b1;
      bus.dm_addr = 32'h200;
      bus.dm_wdata = 32'hCAFE;
      tick();
      chk("s_en", {31'd0, bus.mem_en}, 32'd1);
      chk("s_we", {31'd0, bus.mem_we}, 32'd1);
      chk("s_addr", bus.mem_addr, 32'h200);
      chk("s_wdata", bus.mem_wdata, 32'hCAFE);
      chk("s_stall_if", {31'd0, bus.stall_if}, 32'd1);
      chk("s_stall_mem", {31'd0, bus.stall_mem}, 32'd1);
      bus.mem_ack = 1'b1;
      bus.mem_rdata = 32'h55;
      tick();
      chk("s_dm_done", {31'd0, bus.dm_done}, 32'd1);
      chk("s_store_rdata", bus.dm_rdata, 32'd0);
      chk("s_stall_mem0", {31'd0, bus.stall_mem}, 32'd0);
      chk("s_en_off", {31'd0, bus.mem_en}, 32'd0);
      bus.mem_ack = 1'b0;
      bus.dm_req = 1'b0;
      tick();
      chk("s_if_en", {31'd0, bus.mem_en}, 32'd1);
      chk("s_if_addr", bus.mem_addr, 32'h100);
      chk("s_if_we", {31'd0, bus.mem_we}, 32'd0);
      chk("s_if_wdata", bus.mem_wdata, 32'd0);
      bus.mem_ack = 1'b1;
      bus.mem_rdata = 32'hAAAA_0001;
      tick();
      chk("s_if_done", {31'd0, bus.if_done}, 32'd1);
      chk("s_if_rdata", bus.if_rdata, 32'hAAAA_0001);
      bus.mem_ack = 1'b0;
      bus.if_req = 1'b0;
      tick();
      bus.if_req = 1'b1;
      bus.dm_req = 1'b1;
      bus.dm_we = 1'b0;
      tick();
      chk("s_tie2_addr", bus.mem_addr, 32'h200);
      chk("s_tie2_we", {31'd0, bus.mem_we}, 32'd0);
      bus.mem_ack = 1'b1;
      bus.mem_rdata = 32'h0BAD_F00D;
      tick();
      chk("s_load_done", {31'd0, bus.dm_done}, 32'd1);
      chk("s_load_rdata", bus.dm_rdata, 32'h0BAD_F00D);
      bus.mem_ack = 1'b0;
      bus.if_req = 1'b0;
      bus.dm_req = 1'b0;
      tick();

      // persistent contention, ack latency 2
      do_reset();
      bus.if_req = 1'b1;
      bus.dm_req = 1'b1;
      bus.dm_we = 1'b0;
      tick();
      for (int i = 0; i < 6; i++) begin
         logic is_dm;
         is_dm = (i % 2 == 0);
         chk($sformatf("c%0d_en", i), {31'd0, bus.mem_en}, 32'd1);
         chk($sformatf("c%0d_addr", i), bus.mem_addr,
             is_dm ? 32'h200 : 32'h100);
         tick();
         bus.mem_ack = 1'b1;
         bus.mem_rdata = 32'h1000 + i;
         tick();
         bus.mem_ack = 1'b0;
         if (is_dm) begin
            chk($sformatf("c%0d_dm_done", i), {31'd0, bus.dm_done}, 32'd1);
            chk($sformatf("c%0d_if_idle", i), {31'd0, bus.if_done}, 32'd0);
            chk($sformatf("c%0d_rdata", i), bus.dm_rdata, 32'h1000 + i);
         end else begin
            chk($sformatf("c%0d_if_done", i), {31'd0, bus.if_done}, 32'd1);
            chk($sformatf("c%0d_dm_idle", i), {31'd0, bus.dm_done}, 32'd0);
            chk($sformatf("c%0d_rdata", i), bus.if_rdata, 32'h1000 + i);
         end
         if (i == 5) begin
            bus.if_req = 1'b0;
            bus.dm_req = 1'b0;
         end
         tick();
      end
      chk("c_end_idle", {31'd0, bus.mem_en}, 32'd0);

      // done-cycle re-grant guard
      bus.dm_req = 1'b1;
      bus.dm_we = 1'b0;
      bus.dm_addr = 32'h200;
      tick();
      chk("g_en", {31'd0, bus.mem_en}, 32'd1);
      bus.mem_ack = 1'b1;
      bus.mem_rdata = 32'h77;
      tick();
      chk("g_done", {31'd0, bus.dm_done}, 32'd1);
      bus.mem_ack = 1'b0;
      tick();
      chk("g_no_access", {31'd0, bus.mem_en}, 32'd0);
      chk("g_no_done", {31'd0, bus.dm_done}, 32'd0);
      chk("g_stall", {31'd0, bus.stall_mem}, 32'd1);
      tick();
      chk("g_regrant", {31'd0, bus.mem_en}, 32'd1);
      chk("g_regrant_addr", bus.mem_addr, 32'h200);
      bus.mem_ack = 1'b1;
      bus.mem_rdata = 32'h78;
      tick();
      chk("g_done2", {31'd0, bus.dm_done}, 32'd1);
      bus.mem_ack = 1'b0;
      bus.dm_req = 1'b0;
      tick();

      // ack on the last allowed cycle completes normally
      bus.if_req = 1'b1;
      bus.if_addr = 32'h300;
      tick();
      tick();
      tick();
      tick();
      chk("l_still_busy", {31'd0, bus.mem_en}, 32'd1);
      bus.mem_ack = 1'b1;
      bus.mem_rdata = 32'h4444;
      tick();
      chk("l_done", {31'd0, bus.if_done}, 32'd1);
      chk("l_rdata", bus.if_rdata, 32'h4444);
      chk("l_no_err", {31'd0, bus.bus_err}, 32'd0);
      bus.mem_ack = 1'b0;
      bus.if_req = 1'b0;
      tick();

      // timeout: done 5 cycles after request
      bus.if_req = 1'b1;
      bus.if_addr = 32'h300;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk($sformatf("t_wait%0d", k), {31'd0, bus.if_done}, 32'd0);
      end
      tick();
      chk("t_done", {31'd0, bus.if_done}, 32'd1);
      chk("t_rdata", bus.if_rdata, 32'hDEAD_BEEF);
      chk("t_err", {31'd0, bus.bus_err}, 32'd1);
      chk("t_en_off", {31'd0, bus.mem_en}, 32'd0);
      bus.if_req = 1'b0;
      tick();
      bus.dm_req = 1'b1;
      bus.dm_we = 1'b0;
      tick();
      bus.mem_ack = 1'b1;
      bus.mem_rdata = 32'h1234;
      tick();
      chk("t_good_done", {31'd0, bus.dm_done}, 32'd1);
      chk("t_good_rdata", bus.dm_rdata, 32'h1234);
      chk("t_err_sticky", {31'd0, bus.bus_err}, 32'd1);
      bus.mem_ack = 1'b0;
      bus.dm_req = 1'b0;
      tick();

      // reset mid-transfer
      bus.dm_req = 1'b1;
      bus.dm_we = 1'b1;
      bus.dm_addr = 32'h400;
      bus.dm_wdata = 32'h99;
      tick();
      chk("r_busy", {31'd0, bus.mem_en}, 32'd1);
      rst = 1'b1;
      tick();
      chk("r_en", {31'd0, bus.mem_en}, 32'd0);
      chk("r_we", {31'd0, bus.mem_we}, 32'd0);
      chk("r_addr", bus.mem_addr, 32'd0);
      chk("r_wdata", bus.mem_wdata, 32'd0);
      chk("r_dm_done", {31'd0, bus.dm_done}, 32'd0);
      chk("r_err", {31'd0, bus.bus_err}, 32'd0);
      chk("r_if_rdata", bus.if_rdata, 32'd0);
      chk("r_dm_rdata", bus.dm_rdata, 32'd0);
      rst = 1'b0;
      bus.dm_req = 1'b0;
      bus.mem_ack = 1'b1;
      bus.mem_rdata = 32'hFFFF;
      tick();
      chk("r_late_done", {31'd0, bus.dm_done}, 32'd0);
      chk("r_late_rdata", bus.dm_rdata, 32'd0);
      chk("r_late_en", {31'd0, bus.mem_en}, 32'd0);
      bus.mem_ack = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
